tnkiii_front_linebuf: RTL and testbench

Double-buffered sprite (front layer) line buffer for the TNKIII video path, directly downstream of the front sprite generator. It consumes the serialized front pixel stream `FD[7:0]` and the per-sprite start position `FL_Y[8:0]`, and paints opaque pixels into the write bank at consecutive positions. The read bank is scanned out at display pixel rate to the priority/colour mixer, and each location is cleared to transparent after it is read. The banks swap on every line boundary.

---
 rtl/tnkiii_front_linebuf_if.sv | 32 +++
 rtl/tnkiii_front_linebuf.sv | 112 +++++++++++
 tb/tb_tnkiii_front_linebuf.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tnkiii_front_linebuf_if.sv
// Bus bundle for the TNKIII front-layer line buffer: sprite write stream,
// display read port, bank status.
interface tnkiii_front_linebuf_if #(
    parameter int ADDR_WIDTH = 9
);
    // Strobe semantics, no backpressure: PIX_CEN and RD_CEN are one-clk
    // qualifiers that are always accepted. LD, FL_Y, FD and WR_EN count only
    // in a PIX_CEN cycle. RD_X counts only in an RD_CEN cycle.
    // LINE_SWAP is a one-clk event.
    logic                  PIX_CEN;
    logic                  LD;
    logic [ADDR_WIDTH-1:0] FL_Y;
    logic [7:0]            FD;
    logic                  WR_EN;
    logic                  LINE_SWAP;
    logic                  RD_CEN;
    logic [ADDR_WIDTH-1:0] RD_X;
    logic [7:0]            FRONT_PIX;
    logic                  FRONT_OPAQUE;
    logic                  WR_BANK;
    logic                  BUSY;

    modport master (
        output PIX_CEN, LD, FL_Y, FD, WR_EN, LINE_SWAP, RD_CEN, RD_X,
        input  FRONT_PIX, FRONT_OPAQUE, WR_BANK, BUSY
    );

    modport slave (
        input  PIX_CEN, LD, FL_Y, FD, WR_EN, LINE_SWAP, RD_CEN, RD_X,
        output FRONT_PIX, FRONT_OPAQUE, WR_BANK, BUSY
    );
endinterface

// File: rtl/tnkiii_front_linebuf.sv
// Double-buffered front sprite line buffer: paint into one bank, scan out and
// clear the other. Optional post-reset clear sweep: FRONT_LB_INIT_CLEAR_EN.
module tnkiii_front_linebuf #(
    parameter int         ADDR_WIDTH = 9,
    parameter logic [2:0] TRANSP     = 3'b111
) (
    input  logic                  clk,
    input  logic                  VIDEO_RSTn,
    tnkiii_front_linebuf_if.slave bus
);
    localparam int         DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [7:0] CLR_VAL = {5'b00000, TRANSP};
    localparam logic [7:0] RST_PIX = 8'h07;

    logic [ADDR_WIDTH-1:0] wptr;
    logic                  wr_bank;
    logic [7:0]            front_pix_q;
    logic                  clr_pend;
    logic [ADDR_WIDTH:0]   clr_addr;
    logic                  busy;
    logic [ADDR_WIDTH:0]   sweep_addr;
    logic                  a_we;
    logic [ADDR_WIDTH:0]   a_addr;
    logic [7:0]            a_data;

`ifdef FRONT_LB_INIT_CLEAR_EN
    logic [7:0] mem [0:2*DEPTH-1];

    typedef enum logic {S_IDLE, S_SWEEP} clr_state_e;
    clr_state_e            state_q, state_d;
    logic [ADDR_WIDTH:0]   sweep_q, sweep_d;

    always_ff @(posedge clk) begin
        if (!VIDEO_RSTn) begin
            state_q <= S_SWEEP;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    // BUSY is the observable form of this FSM: high exactly while in SWEEP.
    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        busy    = 1'b0;
        if (state_q == S_SWEEP) begin
            busy    = 1'b1;
            sweep_d = sweep_q + 1'b1;
            if (sweep_q == '1) state_d = S_IDLE;
        end
    end

    assign sweep_addr = sweep_q;
`else
    logic [7:0] mem [0:2*DEPTH-1] = '{default: 8'h07};

    assign busy       = 1'b0;
    assign sweep_addr = '0;
`endif

    // Port A: clear sweep has priority; otherwise opaque pixels of the stream.
    always_comb begin
        a_we   = 1'b0;
        a_addr = {wr_bank, wptr};
        a_data = bus.FD;
        if (busy) begin
            a_we   = VIDEO_RSTn;
            a_addr = sweep_addr;
            a_data = CLR_VAL;
        end else if (VIDEO_RSTn && bus.PIX_CEN && bus.LD && bus.WR_EN &&
                     (bus.FD[2:0] != TRANSP)) begin
            a_we = 1'b1;
        end
    end

    // Port B clear lands one clk after its read, in the bank captured then.
    always_ff @(posedge clk) begin
        if (a_we) mem[a_addr] <= a_data;
        if (clr_pend) mem[clr_addr] <= CLR_VAL;
    end

    always_ff @(posedge clk) begin
        if (!VIDEO_RSTn) begin
            wptr        <= '0;
            wr_bank     <= 1'b0;
            front_pix_q <= RST_PIX;
            clr_pend    <= 1'b0;
            clr_addr    <= '0;
        end else begin
            clr_pend <= 1'b0;
            if (bus.PIX_CEN) begin
                if (!bus.LD)         wptr <= bus.FL_Y;
                else if (bus.WR_EN)  wptr <= wptr + 1'b1;
            end
            if (bus.LINE_SWAP && !busy) wr_bank <= ~wr_bank;
            if (busy) begin
                front_pix_q <= RST_PIX;
            end else if (bus.RD_CEN) begin
                front_pix_q <= mem[{~wr_bank, bus.RD_X}];
                clr_pend    <= 1'b1;
                clr_addr    <= {~wr_bank, bus.RD_X};
            end
        end
    end

    assign bus.FRONT_PIX    = front_pix_q;
    assign bus.FRONT_OPAQUE = (front_pix_q[2:0] != TRANSP);
    assign bus.WR_BANK      = wr_bank;
    assign bus.BUSY         = busy;
endmodule

// File: tb/tb_tnkiii_front_linebuf.sv
// Bench for tnkiii_front_linebuf: directed scenarios plus randomized traffic
// checked against a two-bank array model of the line buffer.
module tb_tnkiii_front_linebuf;
    logic clk;
    logic VIDEO_RSTn;

    tnkiii_front_linebuf_if #(.ADDR_WIDTH(9)) bus ();

    tnkiii_front_linebuf #(.ADDR_WIDTH(9), .TRANSP(3'b111)) dut (
        .clk        (clk),
        .VIDEO_RSTn (VIDEO_RSTn),
        .bus        (bus)
    );

`ifdef FRONT_LB_INIT_CLEAR_EN
    localparam bit SWEEP_EN = 1'b1;
`else
    localparam bit SWEEP_EN = 1'b0;
`endif

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model: two banks of 512 pixels, write bank, write pointer
    logic [7:0] model [0:1][0:511];
    int         mbank;
    int         mwptr;
    logic [7:0] exp_q [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.PIX_CEN   = 1'b0;
        bus.LD        = 1'b1;
        bus.WR_EN     = 1'b0;
        bus.LINE_SWAP = 1'b0;
        bus.RD_CEN    = 1'b0;
    endtask

    task automatic model_reset(input bit wipe);
        mbank = 0;
        mwptr = 0;
        if (wipe)
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < 512; i++) model[b][i] = 8'h07;
    endtask

    // driver tasks
    task automatic load_sprite(input logic [8:0] y);
        bus.PIX_CEN = 1'b1; bus.LD = 1'b0; bus.FL_Y = y;
        tick();
        idle_inputs();
        mwptr = int'(y);
    endtask

    task automatic push_pixel(input logic [7:0] fd, input logic en);
        bus.PIX_CEN = 1'b1; bus.LD = 1'b1; bus.WR_EN = en; bus.FD = fd;
        tick();
        idle_inputs();
        if (en) begin
            if (fd[2:0] != 3'b111) model[mbank][mwptr] = fd;
            mwptr = (mwptr + 1) % 512;
        end
    endtask

    task automatic swap();
        bus.LINE_SWAP = 1'b1;
        tick();
        idle_inputs();
        mbank = mbank ^ 1;
    endtask

    task automatic do_read(input logic [8:0] x, output logic [7:0] pix,
                           output logic opq, output logic [7:0] expv);
        bus.RD_CEN = 1'b1; bus.RD_X = x;
        tick();
        idle_inputs();
        pix  = bus.FRONT_PIX;
        opq  = bus.FRONT_OPAQUE;
        expv = model[mbank ^ 1][int'(x)];
        model[mbank ^ 1][int'(x)] = 8'h07;
        tick();
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (bus.BUSY === 1'b1 && cycles < 2000) begin
            tick();
            cycles++;
        end
    endtask

    task automatic test_reset();
        VIDEO_RSTn = 1'b0;
        idle_inputs();
        bus.FL_Y = '0; bus.FD = '0; bus.RD_X = '0;
        tick();
        tick();
        model_reset(1'b1);
        n_checks++;
        if (bus.FRONT_PIX !== 8'h07) $display("FAIL reset_pix: got %h expected 07", bus.FRONT_PIX);
        else n_pass++;
        n_checks++;
        if (bus.FRONT_OPAQUE !== 1'b0) $display("FAIL reset_opaque: got %b expected 0", bus.FRONT_OPAQUE);
        else n_pass++;
        n_checks++;
        if (bus.WR_BANK !== 1'b0) $display("FAIL reset_bank: got %b expected 0", bus.WR_BANK);
        else n_pass++;
        n_checks++;
        if (bus.BUSY !== SWEEP_EN) $display("FAIL reset_busy: got %b expected %b", bus.BUSY, SWEEP_EN);
        else n_pass++;
        VIDEO_RSTn = 1'b1;
    endtask

    task automatic test_sweep();
        int cycles;
        logic [7:0] pix, expv;
        logic opq;
        logic [8:0] x;
        if (SWEEP_EN) begin
            wait_idle(cycles);
            n_checks++;
            if (cycles != 1024) $display("FAIL sweep_len: got %0d cycles expected 1024", cycles);
            else n_pass++;
        end else begin
            int seen = 0;
            for (int i = 0; i < 8; i++) begin
                if (bus.BUSY !== 1'b0) seen++;
                tick();
            end
            n_checks++;
            if (seen != 0) $display("FAIL no_sweep_busy: got %0d busy cycles expected 0", seen);
            else n_pass++;
        end
        for (int i = 0; i < 3; i++) begin
            x = 9'($urandom_range(0, 511));
            do_read(x, pix, opq, expv);
            n_checks++;
            if (pix !== 8'h07 || opq !== 1'b0)
                $display("FAIL clean_read x=%0d: got %h/%b expected 07/0", x, pix, opq);
            else n_pass++;
        end
    endtask

    task automatic test_sprite();
        logic [7:0] px_in  [4] = '{8'h59, 8'h5F, 8'h5A, 8'h5B};
        logic [7:0] px_out [4] = '{8'h59, 8'h07, 8'h5A, 8'h5B};
        logic [7:0] pix, expv;
        logic opq;
        load_sprite(9'd100);
        for (int i = 0; i < 4; i++) push_pixel(px_in[i], 1'b1);
        swap();
        for (int i = 0; i < 4; i++) begin
            do_read(9'(100 + i), pix, opq, expv);
            n_checks++;
            if (pix !== px_out[i] || opq !== (px_out[i][2:0] != 3'b111))
                $display("FAIL sprite x=%0d: got %h/%b expected %h", 100 + i, pix, opq, px_out[i]);
            else n_pass++;
        end
    endtask

    task automatic test_clear_after_read();
        logic [7:0] pix, expv;
        logic opq;
        swap();
        swap();
        for (int i = 0; i < 4; i++) begin
            do_read(9'(100 + i), pix, opq, expv);
            n_checks++;
            if (pix !== 8'h07 || opq !== 1'b0)
                $display("FAIL cleared x=%0d: got %h/%b expected 07/0", 100 + i, pix, opq);
            else n_pass++;
        end
    endtask

    task automatic test_wrap();
        logic [8:0] xs [5] = '{9'd510, 9'd511, 9'd0, 9'd1, 9'd2};
        logic [7:0] ev [5] = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h07};
        logic [7:0] pix, expv;
        logic opq;
        load_sprite(9'd510);
        for (int i = 0; i < 4; i++) push_pixel(ev[i], 1'b1);
        swap();
        for (int i = 0; i < 5; i++) begin
            do_read(xs[i], pix, opq, expv);
            n_checks++;
            if (pix !== ev[i]) $display("FAIL wrap x=%0d: got %h expected %h", xs[i], pix, ev[i]);
            else n_pass++;
        end
    endtask

    task automatic test_overlap_and_hold();
        logic [7:0] pix, expv;
        logic opq;
        load_sprite(9'd20);
        push_pixel(8'h41, 1'b1);
        load_sprite(9'd20);
        push_pixel(8'h7A, 1'b1);
        load_sprite(9'd30);
        push_pixel(8'h21, 1'b1);
        push_pixel(8'h22, 1'b0);
        push_pixel(8'h23, 1'b1);
        swap();
        do_read(9'd20, pix, opq, expv);
        n_checks++;
        if (pix !== 8'h7A) $display("FAIL overlap: got %h expected 7a", pix);
        else n_pass++;
        do_read(9'd31, pix, opq, expv);
        n_checks++;
        if (pix !== 8'h23) $display("FAIL wr_en_hold: got %h expected 23", pix);
        else n_pass++;
    endtask

    task automatic test_swap_coincident();
        logic [7:0] pix, expv;
        logic opq;
        load_sprite(9'd40);
        push_pixel(8'h33, 1'b1);
        swap();
        load_sprite(9'd50);
        bus.PIX_CEN = 1'b1; bus.LD = 1'b1; bus.WR_EN = 1'b1; bus.FD = 8'h44;
        bus.RD_CEN = 1'b1; bus.RD_X = 9'd40; bus.LINE_SWAP = 1'b1;
        tick();
        idle_inputs();
        model[mbank][mwptr] = 8'h44;
        mwptr = (mwptr + 1) % 512;
        model[mbank ^ 1][40] = 8'h07;
        mbank = mbank ^ 1;
        n_checks++;
        if (bus.FRONT_PIX !== 8'h33) $display("FAIL coincident_read: got %h expected 33", bus.FRONT_PIX);
        else n_pass++;
        n_checks++;
        if (bus.WR_BANK !== mbank[0]) $display("FAIL coincident_bank: got %b expected %b", bus.WR_BANK, mbank[0]);
        else n_pass++;
        tick();
        swap();
        do_read(9'd40, pix, opq, expv);
        n_checks++;
        if (pix !== 8'h07) $display("FAIL coincident_clear: got %h expected 07", pix);
        else n_pass++;
        swap();
        do_read(9'd50, pix, opq, expv);
        n_checks++;
        if (pix !== 8'h44) $display("FAIL coincident_write: got %h expected 44", pix);
        else n_pass++;
    endtask

    task automatic test_reset_midline();
        int cycles;
        logic [7:0] pix, expv;
        logic opq;
        load_sprite(9'd60);
        bus.PIX_CEN = 1'b1; bus.LD = 1'b1; bus.WR_EN = 1'b1; bus.FD = 8'h66;
        VIDEO_RSTn = 1'b0;
        tick();
        idle_inputs();
        model_reset(SWEEP_EN);
        n_checks++;
        if (bus.FRONT_PIX !== 8'h07 || bus.FRONT_OPAQUE !== 1'b0 || bus.WR_BANK !== 1'b0)
            $display("FAIL midline_reset: got %h/%b/%b expected 07/0/0",
                     bus.FRONT_PIX, bus.FRONT_OPAQUE, bus.WR_BANK);
        else n_pass++;
        VIDEO_RSTn = 1'b1;
        if (SWEEP_EN) begin
            wait_idle(cycles);
            n_checks++;
            if (cycles != 1024) $display("FAIL resweep_len: got %0d cycles expected 1024", cycles);
            else n_pass++;
        end
        push_pixel(8'h2C, 1'b1);
        swap();
        do_read(9'd0, pix, opq, expv);
        n_checks++;
        if (pix !== 8'h2C) $display("FAIL wptr_after_reset: got %h expected 2c", pix);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [7:0] pix, expv, fd;
        logic opq;
        logic [8:0] x;
        int op;
        for (int n = 0; n < 400; n++) begin
            op = int'($urandom_range(0, 9));
            if (op == 0) begin
                load_sprite(9'($urandom_range(0, 511)));
            end else if (op <= 5) begin
                fd = {1'b0, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7))};
                push_pixel(fd, op != 5);
            end else if (op == 6) begin
                swap();
            end else begin
                x = (op == 9) ? 9'(mwptr) : 9'($urandom_range(0, 511));
                do_read(x, pix, opq, expv);
                exp_q.push_back(expv);
                expv = exp_q.pop_front();
                n_checks++;
                if (pix !== expv || opq !== (expv[2:0] != 3'b111))
                    $display("FAIL random_read x=%0d: got %h/%b expected %h", x, pix, opq, expv);
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_sprite();
        test_clear_after_read();
        test_wrap();
        test_overlap_and_hold();
        test_swap_coincident();
        test_reset_midline();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
